// File: rtl/mem_access_unit.sv
// MIPS data-memory stage with a wait-state FSM, byte/half/word access and pipeline stall.
// Optional debug read port is compiled in when MEM_ACCESS_DEBUG_EN is defined.
module mem_access_unit #(
  parameter int BITS_SIZE     = 32,
  parameter int SIZE_MEM_DATA = 10,
  parameter int WAIT_STATES   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic [BITS_SIZE-1:0] i_exmem_alu,
  input  logic                 i_exmem_mem_read,
  input  logic                 i_exmem_mem_write,
  input  logic [BITS_SIZE-1:0] i_exmem_mem_register2,
  input  logic [1:0]           i_exmem_size_filter,
  input  logic                 i_exmem_unsigned,
  input  logic [BITS_SIZE-1:0] i_addr_mem_debug,
  output logic [BITS_SIZE-1:0] o_mem_dato,
  output logic [BITS_SIZE-1:0] o_mem_dato_debug,
  output logic                 o_mem_stall,
  output logic                 o_mem_valid,
  output logic                 o_mem_misaligned
);

  localparam int DEPTH = 1 << SIZE_MEM_DATA;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [BITS_SIZE-1:0]     dato_q, dato_d;
  logic [BITS_SIZE-1:0]     mem_q [DEPTH];

  logic                     is_byte, is_half, is_word;
  logic                     req, aligned, accept, fire, wr_en;
  logic [SIZE_MEM_DATA-1:0] idx;
  logic [1:0]               lane;
  logic [3:0]               be;
  logic [BITS_SIZE-1:0]     wdata, rd_word, ld_ext;
  logic [7:0]               rd_byte;
  logic [15:0]              rd_half;

  assign idx     = i_exmem_alu[SIZE_MEM_DATA+1:2];
  assign lane    = i_exmem_alu[1:0];
  assign is_byte = (i_exmem_size_filter == 2'b00);
  assign is_half = (i_exmem_size_filter == 2'b01);
  assign is_word = i_exmem_size_filter[1];
  assign req     = i_exmem_mem_read | i_exmem_mem_write;
  assign aligned = is_byte | (is_half & ~lane[0]) | (is_word & (lane == 2'b00));

  assign o_mem_misaligned = req & ~aligned;
  assign o_mem_stall      = ((state_q == ST_IDLE) & req & aligned) | (state_q == ST_ACCESS);
  assign o_mem_valid      = (state_q == ST_DONE);
  assign o_mem_dato       = dato_q;

  assign accept = i_step & (state_q == ST_IDLE) & req & aligned;
  assign fire   = i_step & (state_q == ST_ACCESS) & (cnt_q == 4'd0);
  assign wr_en  = fire & i_exmem_mem_write;

  always_comb begin
    be    = 4'b1111;
    wdata = i_exmem_mem_register2;
    if (is_byte) begin
      be        = 4'b0000;
      be[lane]  = 1'b1;
      wdata     = {4{i_exmem_mem_register2[7:0]}};
    end else if (is_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wdata = {2{i_exmem_mem_register2[15:0]}};
    end
  end

  assign rd_word = mem_q[idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_ext = rd_word;
    if (is_byte)
      ld_ext = i_exmem_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
    else if (is_half)
      ld_ext = i_exmem_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dato_d  = dato_q;
    if (i_step) begin
      case (state_q)
        ST_IDLE: if (accept) begin
          state_d = ST_ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
        ST_ACCESS: if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_DONE;
          // A simultaneous read is dropped: the store has priority.
          if (i_exmem_mem_read && !i_exmem_mem_write) dato_d = ld_ext;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      dato_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dato_q  <= dato_d;
    end
  end

  // Register-based array so the whole memory can be cleared by reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

`ifdef MEM_ACCESS_DEBUG_EN
  logic unused_bits;
  assign o_mem_dato_debug = mem_q[i_addr_mem_debug[SIZE_MEM_DATA+1:2]];
  assign unused_bits = ^{i_exmem_alu[BITS_SIZE-1:SIZE_MEM_DATA+2],
                         i_addr_mem_debug[BITS_SIZE-1:SIZE_MEM_DATA+2],
                         i_addr_mem_debug[1:0]};
`else
  logic unused_bits;
  assign o_mem_dato_debug = '0;
  assign unused_bits = ^{i_exmem_alu[BITS_SIZE-1:SIZE_MEM_DATA+2], i_addr_mem_debug};
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (WAIT_STATES=2): latency, extension, partial stores,
// misalignment, step gating, reset and the debug port.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        step;
  logic [31:0] alu, wdat, dbg_addr;
  logic        rd, wr, uns;
  logic [1:0]  sz;
  logic [31:0] dato, dato_dbg;
  logic        stall, valid, misal;

  int total = 0;
  int bad   = 0;
  int stall_n, valid_cyc;
  logic [31:0] dato_seen;

  always #5 clk = ~clk;

  mem_access_unit #(.BITS_SIZE(32), .SIZE_MEM_DATA(10), .WAIT_STATES(2)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_step(step),
    .i_exmem_alu(alu), .i_exmem_mem_read(rd), .i_exmem_mem_write(wr),
    .i_exmem_mem_register2(wdat), .i_exmem_size_filter(sz), .i_exmem_unsigned(uns),
    .i_addr_mem_debug(dbg_addr),
    .o_mem_dato(dato), .o_mem_dato_debug(dato_dbg), .o_mem_stall(stall),
    .o_mem_valid(valid), .o_mem_misaligned(misal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Drives one request (inputs changed 1ns after a rising edge = cycle 0) and runs it to DONE.
  task automatic run_acc(input logic w, input logic r, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input int drop_at);
    int cyc;
    wr = w; rd = r; sz = s; uns = u; alu = a; wdat = d;
    cyc = 0; stall_n = 0; valid_cyc = -1; dato_seen = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (valid) begin
        valid_cyc = cyc;
        dato_seen = dato;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc == drop_at)     step = 1'b0;
      if (cyc == drop_at + 3) step = 1'b1;
    end
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; step = 1'b1; alu = '0; wdat = '0; rd = 1'b0; wr = 1'b0;
    sz = 2'b11; uns = 1'b0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_dato", dato, 32'h0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_misal", {31'd0, misal}, 32'd0);
    @(posedge clk); #1;

    run_acc(1, 0, 2'b11, 0, 32'h10, 32'hDEADBEEF, -1);
    chk("sw_stall_cycles", stall_n, 4);
    chk("sw_valid_cycle", valid_cyc, 4);
    run_acc(0, 1, 2'b11, 0, 32'h10, 32'h0, -1);
    chk("lw_stall_cycles", stall_n, 4);
    chk("lw_valid_cycle", valid_cyc, 4);
    chk("lw_data", dato_seen, 32'hDEADBEEF);

    run_acc(1, 0, 2'b11, 0, 32'h20, 32'h000080F0, -1);
    run_acc(0, 1, 2'b00, 0, 32'h20, 32'h0, -1);
    chk("lb_20", dato_seen, 32'hFFFFFFF0);
    run_acc(0, 1, 2'b00, 1, 32'h21, 32'h0, -1);
    chk("lbu_21", dato_seen, 32'h00000080);
    run_acc(0, 1, 2'b01, 0, 32'h20, 32'h0, -1);
    chk("lh_20", dato_seen, 32'hFFFF80F0);
    run_acc(0, 1, 2'b01, 1, 32'h20, 32'h0, -1);
    chk("lhu_20", dato_seen, 32'h000080F0);
    run_acc(0, 1, 2'b10, 1, 32'h20, 32'h0, -1);
    chk("lw_size10", dato_seen, 32'h000080F0);

    run_acc(1, 0, 2'b11, 0, 32'h30, 32'h11223344, -1);
    run_acc(1, 0, 2'b00, 0, 32'h32, 32'h000000AA, -1);
    run_acc(0, 1, 2'b11, 0, 32'h30, 32'h0, -1);
    chk("sb_partial", dato_seen, 32'h11AA3344);
    run_acc(1, 0, 2'b01, 0, 32'h32, 32'h00005566, -1);
    run_acc(0, 1, 2'b11, 0, 32'h30, 32'h0, -1);
    chk("sh_upper", dato_seen, 32'h55663344);
    run_acc(1, 1, 2'b11, 0, 32'h30, 32'h11AA3344, -1);
    chk("rw_write_wins_dato", dato_seen, 32'h55663344);
    run_acc(0, 1, 2'b11, 0, 32'h30, 32'h0, -1);
    chk("rw_write_wins_mem", dato_seen, 32'h11AA3344);

    // Misaligned word store must be ignored entirely.
    wr = 1'b1; sz = 2'b11; alu = 32'h31; wdat = 32'hFFFFFFFF;
    begin
      int vseen = 0;
      int sseen = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (valid) vseen++;
        if (stall) sseen++;
        if (k == 0) chk("sw_misal_flag", {31'd0, misal}, 32'd1);
        @(posedge clk); #1;
      end
      chk("sw_misal_valid_count", vseen, 0);
      chk("sw_misal_stall_count", sseen, 0);
    end
    wr = 1'b0; rd = 1'b1; sz = 2'b01; alu = 32'h33;
    @(negedge clk);
    chk("lh_misal_flag", {31'd0, misal}, 32'd1);
    chk("lh_misal_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rd = 1'b0;
    run_acc(0, 1, 2'b11, 0, 32'h30, 32'h0, -1);
    chk("misal_mem_unchanged", dato_seen, 32'h11AA3344);

    run_acc(0, 1, 2'b11, 0, 32'h10, 32'h0, 2);
    chk("step_valid_cycle", valid_cyc, 7);
    chk("step_stall_cycles", stall_n, 7);
    chk("step_data", dato_seen, 32'hDEADBEEF);

    // Reset in the middle of an ACCESS must drop the pending store.
    wr = 1'b1; sz = 2'b11; alu = 32'h40; wdat = 32'h55;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("rst_mid_dato", dato, 32'h0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_valid", {31'd0, valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_acc(0, 1, 2'b11, 0, 32'h40, 32'h0, -1);
    chk("rst_store_discarded", dato_seen, 32'h0);
    chk("rst_fsm_idle_latency", valid_cyc, 4);
    run_acc(0, 1, 2'b11, 0, 32'h10, 32'h0, -1);
    chk("rst_mem_cleared", dato_seen, 32'h0);

    run_acc(1, 0, 2'b11, 0, 32'h3FC, 32'hCAFEF00D, -1);
    dbg_addr = 32'h3FC;
    @(negedge clk);
`ifdef MEM_ACCESS_DEBUG_EN
    chk("debug_port", dato_dbg, 32'hCAFEF00D);
`else
    chk("debug_port", dato_dbg, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised data-memory stage for the MIPS pipeline, between the EX/MEM and MEM/WB registers. It adds a configurable wait-state FSM to the memory-stage data path, and stalls the pipeline while an access is in flight. It supports byte/half/word loads with sign or zero extension, byte/half/word stores, and misalignment detection. A combinational debug read port serves the debug unit.

## Interface
Parameters:
- BITS_SIZE, 32, datapath and memory word width (must be 32)
- SIZE_MEM_DATA, 10, word-address bits; memory depth is 2^SIZE_MEM_DATA words
- WAIT_STATES, 2, extra cycles per access (0..15)

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_step  in  1  pipeline advance enable from debug unit; low freezes all state
- i_exmem_alu  in  BITS_SIZE  byte address
- i_exmem_mem_read  in  1  load request
- i_exmem_mem_write  in  1  store request
- i_exmem_mem_register2  in  BITS_SIZE  store data
- i_exmem_size_filter  in  2  00 byte, 01 half, 11 word, 10 treated as word
- i_exmem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
- i_addr_mem_debug  in  BITS_SIZE  debug byte address
- o_mem_dato  out  BITS_SIZE  extended load result, registered
- o_mem_dato_debug  out  BITS_SIZE  word at debug address
- o_mem_stall  out  1  hold EX/MEM and earlier stages
- o_mem_valid  out  1  one-cycle pulse: access completed
- o_mem_misaligned  out  1  current request is misaligned, combinational

## Operation
- Word index = addr[SIZE_MEM_DATA+1:2]. Higher address bits are ignored, so accesses wrap.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned request raises o_mem_misaligned and is never accepted.
  - No write occurs, stall stays low, and o_mem_dato holds its value.
- If read and write are both high, the write wins and the read is ignored.
- FSM states: IDLE, ACCESS, DONE. Counter cnt is 4 bits.
  - IDLE: on an aligned request with i_step=1, go to ACCESS and set cnt=WAIT_STATES.
  - ACCESS, cnt≠0: cnt decrements.
  - ACCESS, cnt=0: perform the access and go to DONE.
  - DONE: go to IDLE unconditionally.
- With i_step=0, the FSM, the counter, memory writes and o_mem_dato are all frozen.
- Stores:
  - Byte: data[7:0] is written to lane addr[1:0].
  - Half: data[15:0] is written to lanes {addr[1],1'b0}+1 : {addr[1],1'b0}.
  - Word: the full word is written.
  - Other lanes are untouched.
- Loads:
  - The selected lane is extended to 32 bits per i_exmem_unsigned and registered into o_mem_dato.
  - Word loads ignore i_exmem_unsigned.
- o_mem_stall = (IDLE and aligned request) or ACCESS. It is low in DONE.
- o_mem_valid = 1 only in DONE.
- Request inputs must be held stable from acceptance through DONE; the pipeline is stalled during this window.

## Timing
- Request present in cycle 0 → ACCESS for cycles 1..WAIT_STATES+1 → DONE in cycle WAIT_STATES+2.
  - The store commits, and the load data is captured, at the edge ending the last ACCESS cycle.
  - o_mem_dato is therefore valid in DONE.
- Stall is high for cycles 0..WAIT_STATES+1, i.e. WAIT_STATES+2 cycles.
- Back-to-back requests: the next instruction is sampled in IDLE the cycle after DONE.
- Reset (asynchronous, i_reset=0):
  - FSM→IDLE, cnt=0, o_mem_dato=0, o_mem_valid=0, o_mem_stall=0.
  - All memory words are cleared to 0.
- Reset mid-ACCESS: an uncommitted store is discarded.
- o_mem_dato_debug is combinational from memory contents. A store is visible on the debug port from the cycle after it commits.

## Configuration
- MEM_ACCESS_DEBUG_EN defined: the debug read port is active as described.
- MEM_ACCESS_DEBUG_EN undefined: o_mem_dato_debug is tied to 0, i_addr_mem_debug is unused, and no debug read mux is built.

## Test plan
- Word store then load, WAIT_STATES=2:
  - Store 0xDEADBEEF @0x10, then load word @0x10.
  - Stall is high exactly 4 cycles per access; valid pulses in cycle 4; o_mem_dato=0xDEADBEEF.
- Byte/half extension:
  - Store 0x000080F0 @0x20.
  - lb @0x20 → 0xFFFFFFF0; lbu @0x21 → 0x00000080; lh @0x20 → 0xFFFF80F0; lhu → 0x000080F0.
- Partial store:
  - Word 0x11223344 @0x30, then sb 0xAA @0x32.
  - Word load @0x30 → 0x11AA3344.
- Misaligned:
  - sw @0x31 → o_mem_misaligned=1, stall=0, valid never pulses; memory @0x30 is unchanged.
  - lh @0x33 is flagged the same way.
- i_step gating and reset:
  - Drop i_step for 3 cycles mid-ACCESS → completion slips by exactly 3 cycles.
  - Assert i_reset low mid-ACCESS of sw 0x55 @0x40 → outputs go to 0, FSM is IDLE, word @0x40 reads 0.
- Debug port with macro defined: after sw 0xCAFEF00D @0x3FC, i_addr_mem_debug=0x3FC → o_mem_dato_debug=0xCAFEF00D. Without the macro, the same stimulus gives 0.
